mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: single-port word memory with a fixed-latency miss FSM and a MEM/WB register.
// Optional misaligned-access trap is compiled in when MEM_MISALIGN_TRAP_EN is defined.
module mem_stage #(
   parameter int MEM_DEPTH    = 256,
   parameter int MISS_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hit,
   input  logic [31:0] branchTarget,
   input  logic        zeroFlag,
   input  logic [31:0] ALUResult,
   input  logic [31:0] readData2,
   input  logic [4:0]  writeReg,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        Branch,
   input  logic        RegWrite,
   input  logic        MemToReg,
   output logic        PCSrc,
   output logic [31:0] branchTargetOut,
   output logic        stall,
   output logic [31:0] readDataOut,
   output logic [31:0] ALUResultOut,
   output logic [4:0]  writeRegOut,
   output logic        RegWriteOut,
   output logic        MemToRegOut,
   output logic        misaligned
);

   // state | meaning
   // IDLE  | no miss pending; hit (or no access) completes this cycle, miss starts stalling
   // BUSY  | miss in progress; counter counts remaining stall cycles down to 1
   // DONE  | miss latency served; access commits this cycle regardless of hit
   typedef enum logic [1:0] {IDLE, BUSY, DONE} stateE;

   localparam int AW = $clog2(MEM_DEPTH);

   stateE       state, stateNext;
   logic [3:0]  missCnt, missCntNext;
   logic [31:0] mem [MEM_DEPTH];
   logic [AW-1:0] wordIdx;
   logic        access;
   logic        trap;
   logic        unusedAddrBits;

   assign wordIdx        = ALUResult[AW+1:2];
   assign access         = MemRead | MemWrite;
   assign unusedAddrBits = ^{ALUResult[31:AW+2], ALUResult[1:0]};

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = access && (ALUResult[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   assign PCSrc           = Branch & zeroFlag;
   assign branchTargetOut = branchTarget;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         missCnt <= 4'd0;
      end else begin
         state   <= stateNext;
         missCnt <= missCntNext;
      end
   end

   // A trapped access never misses: it completes immediately with no side effects.
   always_comb begin
      stateNext   = state;
      missCntNext = missCnt;
      stall       = 1'b0;
      case (state)
         IDLE: begin
            if (access && !hit && !trap) begin
               stall       = 1'b1;
               stateNext   = BUSY;
               missCntNext = 4'(MISS_LATENCY - 1);
            end
         end
         BUSY: begin
            stall       = 1'b1;
            missCntNext = missCnt - 4'd1;
            if (missCnt == 4'd1) stateNext = DONE;
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Memory is intentionally not reset; only a committing, non-trapped store writes.
   always_ff @(posedge clk) begin
      if (!rst && !stall && MemWrite && !trap) mem[wordIdx] <= readData2;
   end

   always_ff @(posedge clk) begin
      if (rst || stall) begin
         readDataOut  <= 32'd0;
         ALUResultOut <= 32'd0;
         writeRegOut  <= 5'd0;
         RegWriteOut  <= 1'b0;
         MemToRegOut  <= 1'b0;
         misaligned   <= 1'b0;
      end else begin
         readDataOut  <= (MemRead && !trap) ? mem[wordIdx] : 32'd0;
         ALUResultOut <= ALUResult;
         writeRegOut  <= writeReg;
         RegWriteOut  <= RegWrite & ~trap;
         MemToRegOut  <= MemToReg;
         misaligned   <= trap;
      end
   end

endmodule
